// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
// Loads one CNN layer's weights from a 16-bit valid/ready stream into
// local_mem_weight. Each start command loads one layer.
//
// Optional feature: define WEIGHT_LOAD_CHECKSUM_EN to add the load_checksum
// output, a modulo-2^16 sum of the words accepted in the current load.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start, layer_sel     one-cycle load command; target layer 1/2/4/5/7
//   in_valid, in_data    weight stream input
//   in_ready             high while the FSM is in a STORE state
//   write_weight_*       registered write strobe, address and data to memory
//   weight_fsm_cs        current state encoding
//   weight_store_done    one-cycle pulse in FINISH (last word on the bus)
//   weight_valid         level: the loaded layer's weights are complete
//   loaded_layer         layer held in memory; meaningful while weight_valid=1
//   load_checksum        (WEIGHT_LOAD_CHECKSUM_EN only) sum of accepted words
//
// state    | meaning
// IDLE     | waiting for start with a legal layer_sel
// L1_STORE | accepting layer-1 words (216)
// L2_STORE | accepting layer-2 words (576)
// L4_STORE | accepting layer-4 words (576)
// L5_STORE | accepting layer-5 words (576)
// L7_STORE | accepting layer-7 words (400; bank0 0..199, bank1 200..399)
// FINISH   | last word on the write bus; done pulse; one cycle only
module weight_load_ctrl #(
  parameter int L1_NUM  = 216,
  parameter int L2_NUM  = 576,
  parameter int L4_NUM  = 576,
  parameter int L5_NUM  = 576,
  parameter int L7_NUM  = 400,
  parameter int MAX_NUM = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  layer_sel,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_addr,
  output logic [15:0] write_weight_data,
  output logic [3:0]  weight_fsm_cs,
  output logic        weight_store_done,
  output logic        weight_valid,
  output logic [2:0]  loaded_layer
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  output logic [15:0] load_checksum
`endif
);

  if (L1_NUM > MAX_NUM || L2_NUM > MAX_NUM || L4_NUM > MAX_NUM ||
      L5_NUM > MAX_NUM || L7_NUM > MAX_NUM) begin : g_depth_check
    $error("weight_load_ctrl: a layer word count exceeds MAX_NUM");
  end

  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    L1_STORE = 4'b0001,
    L2_STORE = 4'b0010,
    L4_STORE = 4'b0011,
    L5_STORE = 4'b0100,
    L7_STORE = 4'b0101,
    FINISH   = 4'b1111
  } state_t;

  state_t      state, state_nxt;
  state_t      start_state;
  logic        start_legal;
  logic        start_acc;
  logic        beat;
  logic [15:0] counter;
  logic [15:0] last_idx;
  logic [2:0]  load_sel;

  always_comb begin
    start_state = IDLE;
    start_legal = 1'b1;
    case (layer_sel)
      3'd1:    start_state = L1_STORE;
      3'd2:    start_state = L2_STORE;
      3'd4:    start_state = L4_STORE;
      3'd5:    start_state = L5_STORE;
      3'd7:    start_state = L7_STORE;
      default: start_legal = 1'b0;
    endcase
  end

  always_comb begin
    last_idx = '0;
    case (state)
      L1_STORE: last_idx = 16'(L1_NUM - 1);
      L2_STORE: last_idx = 16'(L2_NUM - 1);
      L4_STORE: last_idx = 16'(L4_NUM - 1);
      L5_STORE: last_idx = 16'(L5_NUM - 1);
      L7_STORE: last_idx = 16'(L7_NUM - 1);
      default:  last_idx = '0;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    in_ready          = 1'b0;
    weight_store_done = 1'b0;
    case (state)
      IDLE: begin
        if (start && start_legal) state_nxt = start_state;
      end
      L1_STORE, L2_STORE, L4_STORE, L5_STORE, L7_STORE: begin
        in_ready = 1'b1;
        if (in_valid && counter == last_idx) state_nxt = FINISH;
      end
      FINISH: begin
        weight_store_done = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat          = in_valid & in_ready;
  assign start_acc     = (state == IDLE) && start && start_legal;
  assign weight_fsm_cs = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter             <= '0;
      write_weight_signal <= 1'b0;
      write_weight_addr   <= '0;
      write_weight_data   <= '0;
      weight_valid        <= 1'b0;
      loaded_layer        <= '0;
      load_sel            <= '0;
    end else begin
      write_weight_signal <= beat;
      if (beat) begin
        write_weight_addr <= counter;
        write_weight_data <= in_data;
        // Hold on the final word so the counter never passes Lx_NUM-1.
        if (counter != last_idx) counter <= counter + 16'd1;
      end
      if (start_acc) begin
        counter      <= '0;
        weight_valid <= 1'b0;
        load_sel     <= layer_sel;
      end
      if (state == FINISH) begin
        weight_valid <= 1'b1;
        loaded_layer <= load_sel;
      end
    end
  end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            load_checksum <= '0;
    else if (start_acc) load_checksum <= '0;
    else if (beat)      load_checksum <= load_checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  layer_sel;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        write_weight_signal;
  logic [15:0] write_weight_addr;
  logic [15:0] write_weight_data;
  logic [3:0]  weight_fsm_cs;
  logic        weight_store_done;
  logic        weight_valid;
  logic [2:0]  loaded_layer;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [15:0] load_checksum;
`endif

  weight_load_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .layer_sel           (layer_sel),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .write_weight_signal (write_weight_signal),
    .write_weight_addr   (write_weight_addr),
    .write_weight_data   (write_weight_data),
    .weight_fsm_cs       (weight_fsm_cs),
    .weight_store_done   (weight_store_done),
    .weight_valid        (weight_valid),
    .loaded_layer        (loaded_layer)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    .load_checksum       (load_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int done_cyc = -1;
  logic [15:0] exp_sum;

  int          q_cyc[$];
  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] store_cs(input logic [2:0] sel);
    case (sel)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd4:    return 4'b0011;
      3'd5:    return 4'b0100;
      3'd7:    return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Write-bus monitor: each presented beat must appear as a strobe exactly one cycle later.
  always @(negedge clk) begin
    if (weight_store_done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (q_cyc.size() > 0 && q_cyc[0] + 1 == cyc) begin
      chk("strobe", write_weight_signal, 1);
      chk("addr", write_weight_addr, q_addr[0]);
      chk("data", write_weight_data, q_data[0]);
      if (write_weight_signal) wr_count++;
      void'(q_cyc.pop_front());
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end else if (write_weight_signal) begin
      chk("unexpected_write", write_weight_signal, 0);
      wr_count++;
    end
  end

  task automatic start_load(input logic [2:0] sel);
    @(negedge clk); #1;
    start = 1'b1;
    layer_sel = sel;
    @(negedge clk); #1;
    start = 1'b0;
    layer_sel = 3'd0;
    exp_sum = '0;
    chk("store_state", weight_fsm_cs, store_cs(sel));
    chk("valid_cleared", weight_valid, 0);
    chk("in_ready_store", in_ready, 1);
  endtask

  // Present n beats; data = index ^ pat, or pat alone when const_data.
  task automatic run_beats(input logic [2:0] sel, input int n, input bit toggle,
                           input bit const_data, input logic [15:0] pat, input int glitch_at);
    int i = 0;
    for (int k = 0; i < n; k++) begin
      if (toggle && (k % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = const_data ? pat : (16'(i) ^ pat);
        q_cyc.push_back(cyc);
        q_addr.push_back(16'(i));
        q_data.push_back(in_data);
        exp_sum = exp_sum + in_data;
        i++;
      end
      start     = (k == glitch_at);
      layer_sel = (k == glitch_at) ? 3'd1 : 3'd0;
      chk("in_ready_store", in_ready, 1);
      if (i == n) chk("last_beat_state", weight_fsm_cs, store_cs(sel));
      @(negedge clk); #1;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    layer_sel = 3'd0;
  endtask

  // Called one cycle after the final beat was presented: FINISH, then IDLE.
  task automatic finish_check(input logic [2:0] sel, input int n, input int w0, input int d0);
    int last_c;
    last_c = cyc - 1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    chk("finish_state", weight_fsm_cs, 4'b1111);
    chk("finish_in_ready", in_ready, 0);
    chk("finish_done", weight_store_done, 1);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    chk("checksum", load_checksum, exp_sum);
`endif
    @(negedge clk); #1;
    chk("idle_after_finish", weight_fsm_cs, 4'b0000);
    chk("done_low", weight_store_done, 0);
    chk("weight_valid_set", weight_valid, 1);
    chk("loaded_layer", loaded_layer, sel);
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("write_count", wr_count - w0, n);
    chk("done_count", done_count - d0, 1);
    chk("done_cycle", done_cyc, last_c + 1);
  endtask

  initial begin
    int w0, d0;
    rst = 1'b1;
    start = 1'b0;
    layer_sel = 3'd0;
    in_valid = 1'b0;
    in_data = 16'h0;
    exp_sum = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", weight_fsm_cs, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wsig", write_weight_signal, 0);
    chk("rst_addr", write_weight_addr, 0);
    chk("rst_data", write_weight_data, 0);
    chk("rst_done", weight_store_done, 0);
    chk("rst_valid", weight_valid, 0);
    chk("rst_layer", loaded_layer, 0);
    #1 rst = 1'b0;

    // L2 load interrupted by reset after 100 beats
    w0 = wr_count;
    start_load(3'd2);
    run_beats(3'd2, 100, 1'b0, 1'b0, 16'h1234, -1);
    chk("pre_rst_state", weight_fsm_cs, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", weight_fsm_cs, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_wsig", write_weight_signal, 0);
    chk("midrst_addr", write_weight_addr, 0);
    chk("midrst_data", write_weight_data, 0);
    chk("midrst_valid", weight_valid, 0);
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 in_valid = 1'b0;
    chk("midrst_writes", wr_count - w0, 100);
    chk("midrst_valid_after", weight_valid, 0);
    chk("midrst_idle", weight_fsm_cs, 0);

    // L1: 216 back-to-back beats, data = index
    w0 = wr_count; d0 = done_count;
    start_load(3'd1);
    run_beats(3'd1, 216, 1'b0, 1'b0, 16'h0000, -1);
    finish_check(3'd1, 216, w0, d0);

    // L7: in_valid toggling every cycle, 400 words over both banks
    w0 = wr_count; d0 = done_count;
    start_load(3'd7);
    run_beats(3'd7, 400, 1'b1, 1'b0, 16'h5A5A, -1);
    finish_check(3'd7, 400, w0, d0);

    // L4 with a stray start mid-load, then an illegal select in IDLE
    w0 = wr_count; d0 = done_count;
    start_load(3'd4);
    run_beats(3'd4, 576, 1'b0, 1'b0, 16'hC3C3, 300);
    finish_check(3'd4, 576, w0, d0);
    @(negedge clk); #1;
    start = 1'b1;
    layer_sel = 3'd3;
    @(negedge clk); #1;
    start = 1'b0;
    layer_sel = 3'd0;
    chk("illegal_sel_state", weight_fsm_cs, 0);
    chk("illegal_sel_in_ready", in_ready, 0);
    @(negedge clk); #1;
    chk("illegal_sel_valid", weight_valid, 1);
    chk("illegal_sel_layer", loaded_layer, 3'd4);

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    w0 = wr_count; d0 = done_count;
    start_load(3'd1);
    run_beats(3'd1, 216, 1'b0, 1'b1, 16'hFFFF, -1);
    finish_check(3'd1, 216, w0, d0);
    chk("checksum_ffff", load_checksum, 16'hFF28);
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", q_cyc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
